// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 mux with manual select and round-robin scan mode.
// Define MUX_SCAN_MASK_EN to add the ch_mask port (bit k=1 disables channel k).
module mux_scan_nto1 #(
    parameter int N_CH  = 4,
    parameter int DW    = 1,
    parameter int DWELL = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   in,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 en,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]      ch_mask,
`endif
    output logic [DW-1:0]        out,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_vld,
    output logic                 out_err
);
    localparam int NP = 1 << SEL_W;
    localparam int IW = NP * DW;
    localparam int CW = $clog2(DWELL + 1);
    localparam int S1 = SEL_W + 1;

    logic [NP-1:0]    mask;
    logic [IW-1:0]    in_x;
    logic [SEL_W-1:0] ptr, cur;
    logic [CW-1:0]    dw_cnt, cnt_eff;
    logic             mode_q, sel_ok, all_masked, expire;

    // Select codes beyond N_CH-1 are padded as masked, so range and mask checks merge.
`ifdef MUX_SCAN_MASK_EN
    assign mask = ~NP'(~ch_mask);
`else
    assign mask = ~NP'({N_CH{1'b1}});
`endif
    assign in_x = IW'(in);

    function automatic logic [S1-1:0] nxt(input logic [S1-1:0] p);
        return (p == S1'(N_CH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] next_on(input logic [SEL_W-1:0] p, input logic [NP-1:0] m);
        logic [S1-1:0]    c;
        logic [SEL_W-1:0] r;
        logic             f;
        c = {1'b0, p};
        r = p;
        f = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            c = nxt(c);
            if (!f && !m[c[SEL_W-1:0]]) begin
                r = c[SEL_W-1:0];
                f = 1'b1;
            end
        end
        return r;
    endfunction

    assign sel_ok     = !mask[sel];
    assign all_masked = &mask;
    assign cur        = mask[ptr] ? next_on(ptr, mask) : ptr;
    // A fresh scan entry or a skip off a masked channel starts a full dwell.
    assign cnt_eff    = (!mode_q || mask[ptr]) ? '0 : dw_cnt;
    assign expire     = cnt_eff == CW'(DWELL - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            out_ch  <= '0;
            out_vld <= 1'b0;
            out_err <= 1'b0;
            ptr     <= '0;
            dw_cnt  <= '0;
            mode_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            out_vld <= 1'b0;
            out_err <= 1'b0;
            if (en && !mode) begin
                out_vld <= sel_ok;
                out_err <= !sel_ok;
                out     <= sel_ok ? in_x[sel*DW +: DW] : '0;
                if (sel_ok) begin
                    out_ch <= sel;
                    ptr    <= sel;
                    dw_cnt <= '0;
                end
            end else if (en && all_masked) begin
                dw_cnt <= '0;
            end else if (en) begin
                out     <= in_x[cur*DW +: DW];
                out_ch  <= cur;
                out_vld <= 1'b1;
                ptr     <= expire ? next_on(cur, mask) : cur;
                dw_cnt  <= expire ? '0 : cnt_eff + 1'b1;
            end
        end
    end
endmodule
